// File: rtl/ld_str_buffer.sv
// Multi-entry load/store buffer for the LC-3b Tomasulo core.
// Holds memory ops in program order, snoops the CDB for missing operands,
// issues one access at a time from the head and broadcasts results on the CDB.
//
// state | meaning
// IDLE  | waiting for the head entry to become ready
// MEM   | memory strobe held until dmem_resp
// CDB   | result held on cdb_req until cdb_grant, then the head is popped
module ld_str_buffer #(
   parameter int data_width = 16,
   parameter int tag_width  = 3,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      flush,
   input  logic                      WE,
   output logic                      full,
   input  logic [3:0]                opcode_in,
   input  logic [data_width-1:0]     Vbase,
   input  logic [data_width-1:0]     Vsrc,
   input  logic [data_width-1:0]     offset_in,
   input  logic                      Vbase_valid_in,
   input  logic                      Vsrc_valid_in,
   input  logic [tag_width-1:0]      Qbase,
   input  logic [tag_width-1:0]      Qsrc,
   input  logic [tag_width-1:0]      dest,
   input  logic                      cdb_in_valid,
   input  logic [tag_width-1:0]      cdb_in_tag,
   input  logic [data_width-1:0]     cdb_in_data,
   input  logic [tag_width-1:0]      rob_head_tag,
   output logic [data_width-1:0]     dmem_addr,
   output logic                      dmem_read,
   output logic                      dmem_write,
   output logic [data_width-1:0]     dmem_wdata,
   output logic [1:0]                dmem_byte_enable,
   input  logic                      dmem_resp,
   input  logic [data_width-1:0]     dmem_rdata,
   output logic                      cdb_req,
   input  logic                      cdb_grant,
   output logic                      cdb_out_valid,
   output logic [tag_width-1:0]      cdb_out_tag,
   output logic [data_width-1:0]     cdb_out_data,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // LC-3b opcode encodings
   localparam logic [3:0] OP_LDB = 4'b0010;
   localparam logic [3:0] OP_STB = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_CDB} state_t;

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_STR) || (op == OP_STB);
   endfunction

   // entry storage
   logic                  r_busy  [DEPTH];
   logic [3:0]            r_op    [DEPTH];
   logic [data_width-1:0] r_off   [DEPTH];
   logic [data_width-1:0] r_vbase [DEPTH];
   logic [data_width-1:0] r_vsrc  [DEPTH];
   logic                  r_vb_ok [DEPTH];
   logic                  r_vs_ok [DEPTH];
   logic [tag_width-1:0]  r_qb    [DEPTH];
   logic [tag_width-1:0]  r_qs    [DEPTH];
   logic [tag_width-1:0]  r_dest  [DEPTH];

   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   state_t                r_state;
   logic                  r_dmem_read;
   logic                  r_dmem_write;
   logic [data_width-1:0] r_dmem_addr;
   logic [data_width-1:0] r_dmem_wdata;
   logic [1:0]            r_dmem_be;
   logic                  r_lsb;
   logic                  r_is_ldb;
   logic                  r_is_st;
   logic                  r_cdb_req;
   logic [tag_width-1:0]  r_cdb_tag;
   logic [data_width-1:0] r_cdb_data;

   logic                  w_full;
   logic                  w_alloc;
   logic                  w_pop;
   logic                  w_vb_cap;
   logic                  w_vs_cap;
   logic [3:0]            w_head_op;
   logic                  w_head_st;
   logic                  w_head_ready;
   logic [data_width-1:0] w_raw;
   logic [7:0]            w_hsrc_b;
   logic [7:0]            w_rbyte;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_alloc  = WE & ~w_full;
   assign w_pop    = r_cdb_req & cdb_grant;

   // operand forwarded from the CDB on the allocation cycle
   assign w_vb_cap = ~Vbase_valid_in & cdb_in_valid & (Qbase == cdb_in_tag);
   assign w_vs_cap = is_store(opcode_in) & ~Vsrc_valid_in & cdb_in_valid & (Qsrc == cdb_in_tag);

   assign w_head_op    = r_op[r_head];
   assign w_head_st    = is_store(w_head_op);
   assign w_head_ready = r_busy[r_head] & r_vb_ok[r_head] &
                         (~w_head_st | (r_vs_ok[r_head] & (r_dest[r_head] == rob_head_tag)));
   assign w_raw        = r_vbase[r_head] + r_off[r_head];
   assign w_hsrc_b     = r_vsrc[r_head][7:0];
   assign w_rbyte      = r_lsb ? dmem_rdata[15:8] : dmem_rdata[7:0];

   assign full             = w_full;
   assign count            = r_count;
   assign dmem_addr        = r_dmem_addr;
   assign dmem_read        = r_dmem_read;
   assign dmem_write       = r_dmem_write;
   assign dmem_wdata       = r_dmem_wdata;
   assign dmem_byte_enable = r_dmem_be;
   assign cdb_req          = r_cdb_req;
   assign cdb_out_valid    = w_pop;
   assign cdb_out_tag      = r_cdb_tag;
   assign cdb_out_data     = r_cdb_data;

   // entry allocation, CDB snooping and release on pop
   always_ff @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_busy[i]  <= 1'b0;
            r_op[i]    <= '0;
            r_off[i]   <= '0;
            r_vbase[i] <= '0;
            r_vsrc[i]  <= '0;
            r_vb_ok[i] <= 1'b0;
            r_vs_ok[i] <= 1'b0;
            r_qb[i]    <= '0;
            r_qs[i]    <= '0;
            r_dest[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc && (PW'(i) == r_tail)) begin
               r_busy[i]  <= 1'b1;
               r_op[i]    <= opcode_in;
               r_off[i]   <= offset_in;
               r_dest[i]  <= dest;
               r_qb[i]    <= Qbase;
               r_qs[i]    <= Qsrc;
               r_vbase[i] <= w_vb_cap ? cdb_in_data : Vbase;
               r_vb_ok[i] <= Vbase_valid_in | w_vb_cap;
               r_vsrc[i]  <= w_vs_cap ? cdb_in_data : Vsrc;
               r_vs_ok[i] <= Vsrc_valid_in | w_vs_cap;
            end else begin
               if (w_pop && (PW'(i) == r_head))
                  r_busy[i] <= 1'b0;
               if (r_busy[i] && cdb_in_valid) begin
                  if (!r_vb_ok[i] && (r_qb[i] == cdb_in_tag)) begin
                     r_vbase[i] <= cdb_in_data;
                     r_vb_ok[i] <= 1'b1;
                  end
                  if (is_store(r_op[i]) && !r_vs_ok[i] && (r_qs[i] == cdb_in_tag)) begin
                     r_vsrc[i]  <= cdb_in_data;
                     r_vs_ok[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // head/tail pointers and occupancy
   always_ff @(posedge clk) begin
      if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc)
            r_tail <= r_tail + PW'(1);
         if (w_pop)
            r_head <= r_head + PW'(1);
         case ({w_alloc, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // issue FSM with registered memory and CDB outputs
   always_ff @(posedge clk) begin
      if (flush) begin
         r_state      <= S_IDLE;
         r_dmem_read  <= 1'b0;
         r_dmem_write <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_dmem_be    <= 2'b00;
         r_lsb        <= 1'b0;
         r_is_ldb     <= 1'b0;
         r_is_st      <= 1'b0;
         r_cdb_req    <= 1'b0;
         r_cdb_tag    <= '0;
         r_cdb_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_head_ready) begin
                  r_state      <= S_MEM;
                  r_dmem_read  <= ~w_head_st;
                  r_dmem_write <= w_head_st;
                  r_dmem_addr  <= {w_raw[data_width-1:1], 1'b0};
                  if ((w_head_op == OP_LDR) || (w_head_op == OP_STR))
                     r_dmem_be <= 2'b11;
                  else
                     r_dmem_be <= w_raw[0] ? 2'b10 : 2'b01;
                  r_dmem_wdata <= (w_head_op == OP_STB) ? {(data_width/8){w_hsrc_b}}
                                                        : r_vsrc[r_head];
                  r_lsb        <= w_raw[0];
                  r_is_ldb     <= (w_head_op == OP_LDB);
                  r_is_st      <= w_head_st;
                  r_cdb_tag    <= r_dest[r_head];
               end
            end
            S_MEM: begin
               if (dmem_resp) begin
                  r_state      <= S_CDB;
                  r_dmem_read  <= 1'b0;
                  r_dmem_write <= 1'b0;
                  r_cdb_req    <= 1'b1;
                  if (r_is_st)
                     r_cdb_data <= '0;
                  else if (r_is_ldb)
                     r_cdb_data <= {{(data_width-8){w_rbyte[7]}}, w_rbyte};
                  else
                     r_cdb_data <= dmem_rdata;
               end
            end
            S_CDB: begin
               if (cdb_grant) begin
                  r_state   <= S_IDLE;
                  r_cdb_req <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ld_str_buffer.sv
// Bench for ld_str_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the buffer's ops.
module tb_ld_str_buffer;

   localparam int DEPTH = 4;
   localparam logic [3:0] OP_LDB = 4'b0010;
   localparam logic [3:0] OP_STB = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;

   logic        clk = 1'b0;
   logic        flush, WE, full;
   logic [3:0]  opcode_in;
   logic [15:0] Vbase, Vsrc, offset_in;
   logic        Vbase_valid_in, Vsrc_valid_in;
   logic [2:0]  Qbase, Qsrc, dest;
   logic        cdb_in_valid;
   logic [2:0]  cdb_in_tag;
   logic [15:0] cdb_in_data;
   logic [2:0]  rob_head_tag;
   logic [15:0] dmem_addr;
   logic        dmem_read, dmem_write;
   logic [15:0] dmem_wdata;
   logic [1:0]  dmem_byte_enable;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;
   logic        cdb_req, cdb_grant, cdb_out_valid;
   logic [2:0]  cdb_out_tag;
   logic [15:0] cdb_out_data;
   logic [2:0]  count;

   always #5 clk = ~clk;

   ld_str_buffer #(.data_width(16), .tag_width(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .flush(flush), .WE(WE), .full(full), .opcode_in(opcode_in),
      .Vbase(Vbase), .Vsrc(Vsrc), .offset_in(offset_in),
      .Vbase_valid_in(Vbase_valid_in), .Vsrc_valid_in(Vsrc_valid_in),
      .Qbase(Qbase), .Qsrc(Qsrc), .dest(dest),
      .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
      .rob_head_tag(rob_head_tag),
      .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_out_valid(cdb_out_valid),
      .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data), .count(count)
   );

   typedef struct {
      logic [3:0]  op;
      logic [15:0] base;
      logic [15:0] src;
      logic [15:0] off;
      logic [2:0]  qb;
      logic [2:0]  qs;
      logic [2:0]  dest;
      bit          vb;
      bit          vs;
   } op_t;

   op_t         q[$];
   int          ph = 0;        // 0: waiting, 1: memory access, 2: awaiting grant
   bit          issued = 0;
   logic [15:0] exp_res = '0;
   logic [15:0] last_addr = '0;
   logic [15:0] last_wdata = '0;
   logic [1:0]  last_be = '0;
   logic [15:0] last_cdb = '0;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_st(input logic [3:0] op);
      return (op == OP_STR) || (op == OP_STB);
   endfunction

   function automatic bit head_ready(input op_t e, input logic [2:0] rob);
      if (!is_st(e.op)) return e.vb;
      return e.vb && e.vs && (e.dest == rob);
   endfunction

   // One clock cycle: inputs are already set; check outputs, advance model.
   task automatic step();
      int          sz0;
      logic [15:0] raw;
      logic [7:0]  b;
      op_t         n;
      op_t         t;
      #1;
      sz0 = q.size();
      chk("count", count, sz0);
      chk("full", full, sz0 == DEPTH);
      chk("cdb_req", cdb_req, ph == 2);
      if (ph == 1 && sz0 > 0) begin
         chk("dmem_read", dmem_read, !is_st(q[0].op));
         chk("dmem_write", dmem_write, is_st(q[0].op));
         if (!issued) begin
            issued = 1;
            raw = q[0].base + q[0].off;
            chk("addr", dmem_addr, {raw[15:1], 1'b0});
            if (q[0].op == OP_LDR || q[0].op == OP_STR) chk("be", dmem_byte_enable, 2'b11);
            else chk("be", dmem_byte_enable, raw[0] ? 2'b10 : 2'b01);
            if (q[0].op == OP_STB) chk("wdata", dmem_wdata, {q[0].src[7:0], q[0].src[7:0]});
            else if (q[0].op == OP_STR) chk("wdata", dmem_wdata, q[0].src);
            last_addr  = dmem_addr;
            last_be    = dmem_byte_enable;
            last_wdata = dmem_wdata;
         end
      end else begin
         chk("dmem_read_idle", dmem_read, 0);
         chk("dmem_write_idle", dmem_write, 0);
      end
      chk("cdb_out_valid", cdb_out_valid, (ph == 2) && cdb_grant);
      if (ph == 2 && cdb_grant && sz0 > 0) begin
         chk("cdb_tag", cdb_out_tag, q[0].dest);
         chk("cdb_data", cdb_out_data, exp_res);
         last_cdb = cdb_out_data;
      end
      if (flush) begin
         q.delete();
         ph = 0;
      end else begin
         case (ph)
            0: if (sz0 > 0 && head_ready(q[0], rob_head_tag)) begin ph = 1; issued = 0; end
            1: if (dmem_resp && sz0 > 0) begin
                  raw = q[0].base + q[0].off;
                  b = raw[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
                  if (is_st(q[0].op)) exp_res = 16'h0000;
                  else if (q[0].op == OP_LDB) exp_res = {{8{b[7]}}, b};
                  else exp_res = dmem_rdata;
                  ph = 2;
               end
            default: if (cdb_grant && sz0 > 0) begin void'(q.pop_front()); ph = 0; end
         endcase
         if (cdb_in_valid) begin
            for (int i = 0; i < q.size(); i++) begin
               t = q[i];
               if (!t.vb && t.qb == cdb_in_tag) begin t.vb = 1; t.base = cdb_in_data; end
               if (is_st(t.op) && !t.vs && t.qs == cdb_in_tag) begin t.vs = 1; t.src = cdb_in_data; end
               q[i] = t;
            end
         end
         if (WE && sz0 < DEPTH) begin
            n.op = opcode_in; n.off = offset_in; n.dest = dest;
            n.qb = Qbase; n.qs = Qsrc;
            n.vb = Vbase_valid_in; n.base = Vbase;
            n.vs = Vsrc_valid_in;  n.src = Vsrc;
            if (!n.vb && cdb_in_valid && Qbase == cdb_in_tag) begin n.vb = 1; n.base = cdb_in_data; end
            if (is_st(n.op) && !n.vs && cdb_in_valid && Qsrc == cdb_in_tag) begin
               n.vs = 1; n.src = cdb_in_data;
            end
            q.push_back(n);
         end
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      flush = 0; WE = 0; cdb_in_valid = 0; dmem_resp = 0; cdb_grant = 0;
      Vbase_valid_in = 1; Vsrc_valid_in = 1; Qbase = 0; Qsrc = 0;
   endtask

   task automatic put(input logic [3:0] op, input logic [15:0] b, input logic [15:0] o,
                      input logic [15:0] s, input logic [2:0] d);
      WE = 1; opcode_in = op; Vbase = b; offset_in = o; Vsrc = s; dest = d;
   endtask

   initial begin
      flush = 1; WE = 0; opcode_in = 0; Vbase = 0; Vsrc = 0; offset_in = 0;
      Vbase_valid_in = 0; Vsrc_valid_in = 0; Qbase = 0; Qsrc = 0; dest = 0;
      cdb_in_valid = 0; cdb_in_tag = 0; cdb_in_data = 0; rob_head_tag = 0;
      dmem_resp = 0; dmem_rdata = 0; cdb_grant = 0;
      repeat (2) @(negedge clk);
      flush = 0;
      #1;
      chk("rst_read", dmem_read, 0);
      chk("rst_write", dmem_write, 0);
      chk("rst_req", cdb_req, 0);
      chk("rst_cdbv", cdb_out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_be", dmem_byte_enable, 0);
      @(negedge clk);

      // ldr with immediate response and grant
      quiet();
      put(OP_LDR, 16'h1000, 16'h0004, 16'h0, 3'd2);
      step();
      WE = 0; dmem_resp = 1; dmem_rdata = 16'hBEEF; cdb_grant = 1;
      repeat (4) step();
      chk("ldr_addr", last_addr, 16'h1004);
      chk("ldr_be", last_be, 2'b11);
      chk("ldr_data", last_cdb, 16'hBEEF);
      chk("ldr_count", count, 0);

      // ldb from odd address, sign-extended upper byte
      quiet();
      put(OP_LDB, 16'h2001, 16'h0000, 16'h0, 3'd4);
      step();
      WE = 0; dmem_resp = 1; dmem_rdata = 16'h80FF; cdb_grant = 1;
      repeat (4) step();
      chk("ldb_addr", last_addr, 16'h2000);
      chk("ldb_be", last_be, 2'b10);
      chk("ldb_data", last_cdb, 16'hFF80);

      // stb waits for its source on tag 5 and for the ROB head
      quiet();
      rob_head_tag = 3'd2;
      put(OP_STB, 16'h3000, 16'h0001, 16'h0, 3'd1);
      Vsrc_valid_in = 0; Qsrc = 3'd5;
      step();
      WE = 0; cdb_in_valid = 1; cdb_in_tag = 3'd5; cdb_in_data = 16'h00AB;
      step();
      cdb_in_valid = 0;
      repeat (2) step();
      rob_head_tag = 3'd1; dmem_resp = 1; cdb_grant = 1;
      repeat (4) step();
      chk("stb_wdata", last_wdata, 16'hABAB);
      chk("stb_be", last_be, 2'b10);
      chk("stb_data", last_cdb, 16'h0000);

      // base forwarded from the CDB on the allocation cycle
      quiet();
      put(OP_LDR, 16'hDEAD, 16'h0010, 16'h0, 3'd6);
      Vbase_valid_in = 0; Qbase = 3'd3;
      cdb_in_valid = 1; cdb_in_tag = 3'd3; cdb_in_data = 16'h4000;
      step();
      quiet(); dmem_resp = 1; cdb_grant = 1;
      repeat (4) step();
      chk("fwd_addr", last_addr, 16'h4010);

      // fill to DEPTH with responses held off; extra WE ignored
      quiet();
      for (int i = 0; i < DEPTH + 1; i++) begin
         put(OP_LDR, 16'h0100 * i, 16'h0002, 16'h0, 3'(i));
         step();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, DEPTH);
      put(OP_LDR, 16'h5000, 16'h0, 16'h0, 3'd7);
      dmem_resp = 1; cdb_grant = 1;
      repeat (3 * DEPTH) step();

      // flush during MEM with a late response
      quiet();
      put(OP_LDR, 16'h6000, 16'h0, 16'h0, 3'd3);
      step();
      WE = 0;
      repeat (2) step();
      flush = 1;
      step();
      flush = 0; dmem_resp = 1; cdb_grant = 1;
      step();
      chk("flush_count", count, 0);
      chk("flush_req", cdb_req, 0);
      chk("flush_read", dmem_read, 0);
      step();

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         flush = ($urandom_range(249) == 0);
         WE = ($urandom_range(1) == 1);
         case ($urandom_range(3))
            0: opcode_in = OP_LDR;
            1: opcode_in = OP_LDB;
            2: opcode_in = OP_STR;
            default: opcode_in = OP_STB;
         endcase
         Vbase = 16'($urandom); Vsrc = 16'($urandom); offset_in = 16'($urandom_range(15));
         Vbase_valid_in = ($urandom_range(9) < 6);
         Vsrc_valid_in  = ($urandom_range(9) < 6);
         Qbase = 3'($urandom_range(7)); Qsrc = 3'($urandom_range(7)); dest = 3'($urandom_range(7));
         cdb_in_valid = ($urandom_range(9) < 4);
         cdb_in_tag = 3'($urandom_range(7)); cdb_in_data = 16'($urandom);
         if (q.size() > 0 && $urandom_range(1) == 1) rob_head_tag = q[0].dest;
         else rob_head_tag = 3'($urandom_range(7));
         dmem_resp = ($urandom_range(9) < 4);
         dmem_rdata = 16'($urandom);
         cdb_grant = ($urandom_range(1) == 1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
